// File: rtl/predictor_pkg.sv
// Shared types and helpers for the fetch-stage branch predictor.
// Holds the 2-bit counter encoding, its reset value and update rules.
package predictor_pkg;

    typedef enum logic [1:0] {
        STRONG_NT = 2'b00,
        WEAK_NT   = 2'b01,
        WEAK_T    = 2'b10,
        STRONG_T  = 2'b11
    } ctr_e;

    localparam ctr_e CTR_RESET = WEAK_NT;

    // Saturating step of a trained counter.
    function automatic ctr_e ctr_next(input ctr_e ctr, input logic taken);
        ctr_e nxt;
        unique case (ctr)
            STRONG_NT: nxt = taken ? WEAK_NT  : STRONG_NT;
            WEAK_NT:   nxt = taken ? WEAK_T   : STRONG_NT;
            WEAK_T:    nxt = taken ? STRONG_T : WEAK_NT;
            STRONG_T:  nxt = taken ? STRONG_T : WEAK_T;
            default:   nxt = CTR_RESET;
        endcase
        return nxt;
    endfunction

    // Initial counter for a freshly allocated entry.
    function automatic ctr_e ctr_alloc(input logic taken);
        return taken ? WEAK_T : WEAK_NT;
    endfunction

endpackage

// File: rtl/sat_counter_32.sv
// 32-bit event counter that holds at all-ones instead of wrapping.
// Ports: clk, rst (sync, active-high), inc (count enable), count (value).
module sat_counter_32 (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc,
    output logic [31:0] count
);

    logic [31:0] count_q;
    logic [31:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != 32'hFFFF_FFFF)) begin
            count_d = count_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= 32'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BHT+BTB: zero-latency lookup on pcF, training from Execute.
// Ports: clk/rst, pcF -> branch_predictF/PCPredF, Execute update bundle,
// mispredictE, and saturating branch_count / mispredict_count.
module branch_predictor
    import predictor_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int INDEX_BITS = 6,
    parameter int TAG_BITS   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] pcF,
    output logic                  branch_predictF,
    output logic [DATA_WIDTH-1:0] PCPredF,
    input  logic                  update_validE,
    input  logic [DATA_WIDTH-1:0] pcE,
    input  logic                  takenE,
    input  logic [DATA_WIDTH-1:0] PCTargetE,
    input  logic                  branch_predictE,
    output logic                  mispredictE,
    output logic [31:0]           branch_count,
    output logic [31:0]           mispredict_count
);

    localparam int ENTRIES = 1 << INDEX_BITS;
    localparam int TAG_LO  = INDEX_BITS + 2;
    localparam int TAG_HI  = INDEX_BITS + TAG_BITS + 1;

    logic                  valid_q  [ENTRIES];
    ctr_e                  ctr_q    [ENTRIES];
    logic [TAG_BITS-1:0]   tag_q    [ENTRIES];
    logic [DATA_WIDTH-1:0] target_q [ENTRIES];

    logic [INDEX_BITS-1:0] idxF;
    logic [INDEX_BITS-1:0] idxE;
    logic [TAG_BITS-1:0]   tagF;
    logic [TAG_BITS-1:0]   tagE;
    logic                  hitF;
    logic                  hitE;
    ctr_e                  ctr_d;

    // pc[1:0] and bits above the tag play no part in indexing or tagging.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{pcF[1:0], pcF[DATA_WIDTH-1:TAG_HI+1],
                              pcE[1:0], pcE[DATA_WIDTH-1:TAG_HI+1]};

    assign idxF = pcF[TAG_LO-1:2];
    assign tagF = pcF[TAG_HI:TAG_LO];
    assign idxE = pcE[TAG_LO-1:2];
    assign tagE = pcE[TAG_HI:TAG_LO];

    // Lookup reads the registered table directly; no bypass from Execute.
    assign hitF = valid_q[idxF] && (tag_q[idxF] == tagF);
    assign branch_predictF = hitF && ctr_q[idxF][1];
    assign PCPredF = branch_predictF ? target_q[idxF]
                                     : pcF + DATA_WIDTH'(4);

    assign hitE = valid_q[idxE] && (tag_q[idxE] == tagE);
    assign mispredictE = update_validE && (takenE != branch_predictE);

    assign ctr_d = hitE ? ctr_next(ctr_q[idxE], takenE)
                        : ctr_alloc(takenE);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= CTR_RESET;
            end
        end else if (update_validE) begin
            valid_q[idxE] <= 1'b1;
            ctr_q[idxE]   <= ctr_d;
        end
    end

    // Tags and targets need no reset; valid gates them. A hit that
    // resolves not-taken keeps the previously learned target.
    always_ff @(posedge clk) begin
        if (!rst && update_validE) begin
            tag_q[idxE] <= tagE;
            if (!hitE || takenE) begin
                target_q[idxE] <= PCTargetE;
            end
        end
    end

    sat_counter_32 u_branch_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (update_validE),
        .count (branch_count)
    );

    sat_counter_32 u_mispredict_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (mispredictE),
        .count (mispredict_count)
    );

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor.
// Inputs change 1ns after the rising edge; outputs are checked mid-cycle.
module tb_branch_predictor;

    logic        clk;
    logic        rst;
    logic [31:0] pcF;
    logic        branch_predictF;
    logic [31:0] PCPredF;
    logic        update_validE;
    logic [31:0] pcE;
    logic        takenE;
    logic [31:0] PCTargetE;
    logic        branch_predictE;
    logic        mispredictE;
    logic [31:0] branch_count;
    logic [31:0] mispredict_count;

    int total = 0;
    int bad   = 0;

    branch_predictor dut (
        .clk              (clk),
        .rst              (rst),
        .pcF              (pcF),
        .branch_predictF  (branch_predictF),
        .PCPredF          (PCPredF),
        .update_validE    (update_validE),
        .pcE              (pcE),
        .takenE           (takenE),
        .PCTargetE        (PCTargetE),
        .branch_predictE  (branch_predictE),
        .mispredictE      (mispredictE),
        .branch_count     (branch_count),
        .mispredict_count (mispredict_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one resolve for a cycle, then drop update_validE.
    task automatic resolve(input logic [31:0] pc, input logic tk,
                           input logic [31:0] tgt, input logic pred);
        pcE = pc;
        takenE = tk;
        PCTargetE = tgt;
        branch_predictE = pred;
        update_validE = 1'b1;
        tick();
        update_validE = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        update_validE = 1'b0;
        pcE = '0;
        takenE = 1'b0;
        PCTargetE = '0;
        branch_predictE = 1'b0;
        pcF = 32'h100;
        tick();
        tick();
        rst = 1'b0;
        #1;
        total++;
        if (branch_predictF !== 1'b0) begin
            bad++;
            $display("FAIL reset_pred got=%0b exp=0", branch_predictF);
        end
        total++;
        if (PCPredF !== 32'h104) begin
            bad++;
            $display("FAIL reset_pcpred got=%h exp=00000104", PCPredF);
        end
        total++;
        if (branch_count !== 32'd0 || mispredict_count !== 32'd0) begin
            bad++;
            $display("FAIL reset_counts got=%0d/%0d exp=0/0",
                     branch_count, mispredict_count);
        end
    endtask

    task automatic test_alloc_taken();
        pcE = 32'h100;
        takenE = 1'b1;
        PCTargetE = 32'h80;
        branch_predictE = 1'b0;
        update_validE = 1'b1;
        #1;
        total++;
        if (mispredictE !== 1'b1) begin
            bad++;
            $display("FAIL alloc_mispredE got=%0b exp=1", mispredictE);
        end
        tick();
        update_validE = 1'b0;
        pcF = 32'h100;
        #1;
        total++;
        if (branch_predictF !== 1'b1 || PCPredF !== 32'h80) begin
            bad++;
            $display("FAIL alloc_lookup got=%0b/%h exp=1/00000080",
                     branch_predictF, PCPredF);
        end
        total++;
        if (branch_count !== 32'd1 || mispredict_count !== 32'd1) begin
            bad++;
            $display("FAIL alloc_counts got=%0d/%0d exp=1/1",
                     branch_count, mispredict_count);
        end
        // Low PC bits are ignored for lookup.
        pcF = 32'h103;
        #1;
        total++;
        if (branch_predictF !== 1'b1 || PCPredF !== 32'h80) begin
            bad++;
            $display("FAIL unaligned_lookup got=%0b/%h exp=1/00000080",
                     branch_predictF, PCPredF);
        end
    endtask

    // Entry at 0x100 starts WEAK_T: NT,NT,NT -> 01,00,00; then T,T -> 01,10.
    task automatic test_saturate_down();
        logic exp_pred [5];
        logic tk       [5];
        logic pred     [5];
        exp_pred = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        tk       = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        pred     = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        pcF = 32'h100;
        for (int i = 0; i < 5; i++) begin
            resolve(32'h100, tk[i], (i == 4) ? 32'h200 : 32'h80, pred[i]);
            #1;
            total++;
            if (branch_predictF !== exp_pred[i]) begin
                bad++;
                $display("FAIL ctr_step%0d got=%0b exp=%0b",
                         i, branch_predictF, exp_pred[i]);
            end
        end
        total++;
        if (PCPredF !== 32'h200) begin
            bad++;
            $display("FAIL target_rewrite got=%h exp=00000200", PCPredF);
        end
        total++;
        if (branch_count !== 32'd6 || mispredict_count !== 32'd4) begin
            bad++;
            $display("FAIL sat_counts got=%0d/%0d exp=6/4",
                     branch_count, mispredict_count);
        end
    endtask

    task automatic test_alias();
        pcF = 32'h4100;
        #1;
        total++;
        if (branch_predictF !== 1'b0 || PCPredF !== 32'h4104) begin
            bad++;
            $display("FAIL alias_miss got=%0b/%h exp=0/00004104",
                     branch_predictF, PCPredF);
        end
        resolve(32'h4100, 1'b0, 32'h999, 1'b0);
        pcF = 32'h100;
        #1;
        total++;
        if (branch_predictF !== 1'b0 || PCPredF !== 32'h104) begin
            bad++;
            $display("FAIL alias_evict got=%0b/%h exp=0/00000104",
                     branch_predictF, PCPredF);
        end
    endtask

    task automatic test_same_cycle();
        resolve(32'h100, 1'b0, 32'h300, 1'b0);
        pcF = 32'h100;
        pcE = 32'h100;
        takenE = 1'b1;
        PCTargetE = 32'h300;
        branch_predictE = 1'b0;
        update_validE = 1'b1;
        #1;
        total++;
        if (branch_predictF !== 1'b0 || PCPredF !== 32'h104) begin
            bad++;
            $display("FAIL same_cycle_old got=%0b/%h exp=0/00000104",
                     branch_predictF, PCPredF);
        end
        tick();
        update_validE = 1'b0;
        #1;
        total++;
        if (branch_predictF !== 1'b1 || PCPredF !== 32'h300) begin
            bad++;
            $display("FAIL same_cycle_new got=%0b/%h exp=1/00000300",
                     branch_predictF, PCPredF);
        end
        total++;
        if (branch_count !== 32'd9 || mispredict_count !== 32'd5) begin
            bad++;
            $display("FAIL same_cycle_counts got=%0d/%0d exp=9/5",
                     branch_count, mispredict_count);
        end
    endtask

    task automatic test_wrap();
        pcF = 32'hFFFF_FFFC;
        #1;
        total++;
        if (branch_predictF !== 1'b0 || PCPredF !== 32'h0) begin
            bad++;
            $display("FAIL pc_wrap got=%0b/%h exp=0/00000000",
                     branch_predictF, PCPredF);
        end
    endtask

    task automatic test_reset_with_update();
        pcE = 32'h100;
        takenE = 1'b1;
        PCTargetE = 32'h300;
        branch_predictE = 1'b0;
        update_validE = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        update_validE = 1'b0;
        pcF = 32'h100;
        #1;
        total++;
        if (branch_predictF !== 1'b0 || PCPredF !== 32'h104) begin
            bad++;
            $display("FAIL rst_discard got=%0b/%h exp=0/00000104",
                     branch_predictF, PCPredF);
        end
        total++;
        if (branch_count !== 32'd0 || mispredict_count !== 32'd0) begin
            bad++;
            $display("FAIL rst_counts got=%0d/%0d exp=0/0",
                     branch_count, mispredict_count);
        end
    endtask

    task automatic test_count_saturate();
        dut.u_branch_cnt.count_q = 32'hFFFF_FFFE;
        dut.u_mispredict_cnt.count_q = 32'hFFFF_FFFE;
        resolve(32'h500, 1'b1, 32'h40, 1'b0);
        #1;
        total++;
        if (branch_count !== 32'hFFFF_FFFF
            || mispredict_count !== 32'hFFFF_FFFF) begin
            bad++;
            $display("FAIL cnt_reach_max got=%h/%h exp=ffffffff/ffffffff",
                     branch_count, mispredict_count);
        end
        resolve(32'h500, 1'b0, 32'h40, 1'b1);
        #1;
        total++;
        if (branch_count !== 32'hFFFF_FFFF
            || mispredict_count !== 32'hFFFF_FFFF) begin
            bad++;
            $display("FAIL cnt_hold got=%h/%h exp=ffffffff/ffffffff",
                     branch_count, mispredict_count);
        end
    endtask

    initial begin
        test_reset();
        test_alloc_taken();
        test_saturate_down();
        test_alias();
        test_same_cycle();
        test_wrap();
        test_reset_with_update();
        test_count_saturate();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
